// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data memory controller: FSM state encoding,
// access size encodings, error-cause bit positions and a helper that tells
// whether a size code is legal in the current build.
//
// Build option: DMEM_SUBWORD_EN
//   defined   -> byte, half and word accesses are legal
//   undefined -> only word accesses are legal
// ---------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Each error cause gets its own bit so the latched vector records why a
    // request was refused; any set bit turns the response into an error.
    localparam int ERR_W        = 4;
    localparam int ERR_CONFLICT = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_ALIGN    = 2;
    localparam int ERR_SIZE     = 3;

    typedef logic [ERR_W-1:0] err_vec_t;

    // Size code 3 is never legal; without sub-word support only the word
    // size is accepted.
    function automatic logic sizeIllegal(input logic [1:0] sz);
`ifdef DMEM_SUBWORD_EN
        return sz == 2'd3;
`else
        return sz != SZ_WORD;
`endif
    endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// DEPTH x DATA_W storage with one write enable per byte lane and a
// combinational (asynchronous) word read. Contents are not initialised.
//
// Ports:
//   clk_i    - clock, writes happen on the rising edge
//   we_i     - per-byte write enables
//   addr_i   - word index shared by read and write
//   wdata_i  - write data, already positioned in its byte lanes
//   rdata_o  - full word at addr_i
// ---------------------------------------------------------------------------
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic [DATA_W/8-1:0]   we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Byte-lane writes leave unselected lanes of the word untouched.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Fixed-latency data memory controller. A request is accepted in IDLE,
// waits LATENCY cycles in WAIT, and completes with a one-cycle RESP where
// valid (and possibly err) is asserted. Writes commit on the edge entering
// RESP; read data is registered on the same edge and held until the next
// successful read.
//
// Build option: DMEM_SUBWORD_EN enables byte/half accesses with lane
// steering and zero/sign extension; without it only word accesses are legal.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset, aborts any access in flight
//   MemRead   - read request strobe (sampled in IDLE only)
//   MemWrite  - write request strobe (sampled in IDLE only)
//   a_in      - byte address
//   data_in   - store data, LSB-aligned for sub-word stores
//   size      - 0 byte, 1 half, 2 word
//   sign_ext  - sign-extend sub-word loads
//   ready     - high in IDLE, request can be accepted
//   valid     - one-cycle response strobe
//   err       - response is an error (no write, data_out unchanged)
//   data_out  - last successful load result
// ---------------------------------------------------------------------------
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       a_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic              ready,
    output logic              valid,
    output logic              err,
    output logic [DATA_W-1:0] data_out
);

    localparam int         NB       = DATA_W / 8;
    localparam int         OFF_W    = $clog2(NB);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [AW-1:0]     idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              isWrite_q;
    err_vec_t          errVec_q;
    logic [DATA_W-1:0] dataOut_q;

    logic              accept;
    logic              commit;
    err_vec_t          reqErr;
    logic [31:0]       reqIdx;
    logic [NB-1:0]     byteEn;
    logic [NB-1:0]     memWe;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;
    logic [DATA_W-1:0] loadData;

`ifdef DMEM_SUBWORD_EN
    localparam logic [NB-1:0] BE_BYTE = NB'(1);
    localparam logic [NB-1:0] BE_HALF = NB'(3);

    logic [1:0]        size_q;
    logic              signExt_q;
    logic [OFF_W-1:0]  lane_q;
    logic [DATA_W-1:0] laneWord;
`else
    logic              unusedSignExt;
    assign unusedSignExt = sign_ext;
`endif

    // The full 32-bit index is range-checked so addresses beyond DEPTH are
    // refused rather than wrapping onto a low word.
    assign reqIdx = a_in >> OFF_W;

    always_comb begin
        reqErr               = '0;
        reqErr[ERR_CONFLICT] = MemRead & MemWrite;
        reqErr[ERR_RANGE]    = (reqIdx >= 32'(DEPTH));
        reqErr[ERR_ALIGN]    = ((size == SZ_WORD) && (a_in[OFF_W-1:0] != '0)) ||
                               ((size == SZ_HALF) && a_in[0]);
        reqErr[ERR_SIZE]     = sizeIllegal(size);
    end

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter is loaded with LATENCY-1 and WAIT exits when it reads
    // zero, so WAIT lasts exactly LATENCY cycles. The exit edge is the
    // commit edge for both stores and load data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request payload needs no reset: it is only consumed after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q     <= reqIdx[AW-1:0];
            wdata_q   <= data_in;
            isWrite_q <= MemWrite;
`ifdef DMEM_SUBWORD_EN
            size_q    <= size;
            signExt_q <= sign_ext;
            lane_q    <= a_in[OFF_W-1:0];
`endif
        end
    end

    // Error causes and load result; data_out only moves on a clean read.
    always_ff @(posedge clk) begin
        if (rst) begin
            errVec_q  <= '0;
            dataOut_q <= '0;
        end else begin
            if (accept) begin
                errVec_q <= reqErr;
            end
            if (commit && !isWrite_q && (errVec_q == '0)) begin
                dataOut_q <= loadData;
            end
        end
    end

    // Lane steering: stores are shifted up into their byte lanes, loads are
    // shifted down to bit 0 and then zero- or sign-extended.
    always_comb begin
        byteEn   = '1;
        memWdata = wdata_q;
        loadData = memRdata;
`ifdef DMEM_SUBWORD_EN
        laneWord = memRdata >> {lane_q, 3'b000};
        case (size_q)
            SZ_BYTE: begin
                byteEn   = BE_BYTE << lane_q;
                memWdata = wdata_q << {lane_q, 3'b000};
                loadData = {{(DATA_W-8){signExt_q & laneWord[7]}}, laneWord[7:0]};
            end
            SZ_HALF: begin
                byteEn   = BE_HALF << lane_q;
                memWdata = wdata_q << {lane_q, 3'b000};
                loadData = {{(DATA_W-16){signExt_q & laneWord[15]}}, laneWord[15:0]};
            end
            default: begin
                byteEn = '1;
            end
        endcase
`endif
    end

    // A reset landing on the commit edge must not let the store through.
    assign memWe = (commit && isWrite_q && (errVec_q == '0) && !rst) ? byteEn : '0;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk_i   (clk),
        .we_i    (memWe),
        .addr_i  (idx_q),
        .wdata_i (memWdata),
        .rdata_o (memRdata)
    );

    assign ready    = (state_q == IDLE);
    assign valid    = (state_q == RESP);
    assign err      = (state_q == RESP) && (errVec_q != '0);
    assign data_out = dataOut_q;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 1024, number of words.
REQ-003 SHALL have parameter LATENCY, default 2, access latency in cycles (legal 1..8).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports MemRead, MemWrite  input  1 each  request strobes.
REQ-007 SHALL have port a_in  input  32  byte address.
REQ-008 SHALL have port data_in  input  DATA_W  write data, LSB-aligned for sub-word stores.
REQ-009 SHALL have ports size (input, 2; 0=byte, 1=half, 2=word) and sign_ext (input, 1; loads only).
REQ-010 SHALL have outputs ready (1), valid (1), err (1) and data_out (DATA_W).

Function
REQ-011 SHALL use FSM states IDLE, WAIT, RESP; ready=1 only in IDLE.
REQ-012 SHALL accept a request in IDLE when MemRead or MemWrite is 1, latching a_in, data_in, size, sign_ext and op; go to WAIT.
REQ-013 SHALL stay in WAIT for LATENCY cycles (down-counter loaded with LATENCY-1), then enter RESP; valid=1 for exactly the RESP cycle, then return to IDLE.
REQ-014 SHALL therefore assert valid LATENCY+1 cycles after the accept edge; back-to-back accepts are LATENCY+2 cycles apart.
REQ-015 SHALL ignore MemRead/MemWrite outside IDLE.
REQ-016 SHALL commit writes to storage on the edge entering RESP, touching only the byte lanes selected by size and a_in low bits.
REQ-017 SHALL present read data on data_out in RESP: selected lane shifted to bit 0, zero- or sign-extended per sign_ext; data_out holds until the next read response.
REQ-018 SHALL flag err in RESP, with no write committed and data_out unchanged, when: MemRead and MemWrite both 1 at accept; word index >= DEPTH; address misaligned for size (half: a_in[0]!=0; word: a_in[1:0]!=0); size=3.
REQ-019 SHALL compute word index as a_in >> log2(DATA_W/8); out-of-range addresses SHALL NOT alias.
REQ-020 SHALL not initialise storage contents; reads of never-written words are undefined.

Reset
REQ-021 SHALL on rst force state IDLE, counter 0, valid=0, err=0, data_out=0; ready=1 the cycle after rst deasserts.
REQ-022 SHALL abort an in-flight access on rst with no write committed and no valid pulse.
REQ-023 SHALL give rst priority over a simultaneous request.

Configuration
REQ-024 SHALL use macro DMEM_SUBWORD_EN: defined -> byte/half accesses per REQ-016/017; undefined -> only size=2 legal, any other size gives err, sign_ext ignored, lane logic absent.

Structure
REQ-025 SHALL place the state enum, size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and error condition constants in package dmem_pkg.
REQ-026 SHALL instantiate one sub-module dmem_array: DEPTH x DATA_W storage with per-byte write enables and combinational word read.

Verification
REQ-027 SHALL cover word write 0xDEADBEEF @0x10 then word read @0x10 (LATENCY=2) -> valid 3 cycles after accept, data_out=0xDEADBEEF, err=0.
REQ-028 SHALL cover byte write 0x80 @0x13, then signed byte read @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word read @0x10 -> 0x80ADBEEF.
REQ-029 SHALL cover half read @0x11 and word access @0x1002 with DEPTH=1024 (index 1024) -> err=1, data_out unchanged, memory unchanged.
REQ-030 SHALL cover MemRead=MemWrite=1 -> err=1 at RESP, no write; MemWrite pulsed during WAIT -> ignored.
REQ-031 SHALL cover rst asserted in WAIT of write 0x12345678 @0x20 -> no valid pulse; subsequent read @0x20 returns prior contents.
REQ-032 SHALL cover build without DMEM_SUBWORD_EN: byte read @0x10 -> err=1; word access behaves as REQ-027.
